// File: rtl/Noc_parameters.sv
// Shared constants and types for the NoC output-port VC arbiter.
// Holds the FSM state enum and a one-hot to index helper.
package Noc_parameters;

    localparam int Noc_VC_Channel = 4;
    localparam int STALL_W = 16;

    typedef enum logic {
        IDLE,
        LOCKED
    } e_vc_arb_state;

    function automatic int onehot_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/noc_port_vc_arbiter_if.sv
// Per-port VC arbitration bundle: VC flit status in, grant and
// port status out.
interface noc_port_vc_arbiter_if
    import Noc_parameters::*;
#(
    parameter int CHANNELS = Noc_VC_Channel
);

    logic [CHANNELS-1:0] request;
    logic [CHANNELS-1:0] free;
    logic [CHANNELS-1:0] start_of_packet;
    logic [CHANNELS-1:0] end_of_packet;
    logic [CHANNELS-1:0] grant;
    logic                busy;
    logic                stall_error;
    logic                clear_error;

    modport master (
        output request,
        output free,
        output start_of_packet,
        output end_of_packet,
        output clear_error,
        input  grant,
        input  busy,
        input  stall_error
    );

    modport slave (
        input  request,
        input  free,
        input  start_of_packet,
        input  end_of_packet,
        input  clear_error,
        output grant,
        output busy,
        output stall_error
    );

endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin pick: the search starts at the
// index after last_owner and wraps to 0.
module noc_rr_arbiter
    import Noc_parameters::*;
#(
    parameter int CHANNELS = Noc_VC_Channel,
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] eligible,
    input  logic [IW-1:0]       last_owner,
    output logic [CHANNELS-1:0] winner,
    output logic                valid
);

    int j;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        j      = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            j = int'(last_owner) + i;
            if (j >= CHANNELS) j = j - CHANNELS;
            if (!valid && eligible[j[IW-1:0]]) begin
                winner[j[IW-1:0]] = 1'b1;
                valid             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_port_vc_arbiter.sv
// Output-port VC arbiter: locks a VC for a whole packet, hands
// over with zero bubble on the tail, flags stalled owners.
module noc_port_vc_arbiter
    import Noc_parameters::*;
#(
    parameter int CHANNELS    = Noc_VC_Channel,
    parameter int STALL_LIMIT = 255
) (
    input  logic noc_clk,
    input  logic noc_rst,
    noc_port_vc_arbiter_if.slave port
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);

    e_vc_arb_state       state, state_nx;
    logic [CHANNELS-1:0] grant_q, grant_nx;
    logic [CHANNELS-1:0] eligible, winner;
    logic [IW-1:0]       last_owner, last_nx;
    logic [IW-1:0]       owner_idx, arb_last;
    logic [STALL_W-1:0]  stall_cnt, stall_nx;
    logic                err_q, err_nx;
    logic                win_valid;
    logic                release_c;
    logic                xfer;

    assign owner_idx = IW'(onehot_idx(32'(grant_q)));
    assign xfer      = |(grant_q & port.request & port.free);
    assign release_c = (state == LOCKED) &&
                       (|(grant_q & port.end_of_packet));

    // The owner's sop during its tail belongs to the flit being
    // consumed, so the owner never re-wins in its release cycle.
    assign eligible  = port.request & port.start_of_packet & ~grant_q;
    assign arb_last  = (state == LOCKED) ? owner_idx : last_owner;

    noc_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr (
        .eligible   (eligible),
        .last_owner (arb_last),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        last_nx  = last_owner;
        stall_nx = stall_cnt;
        err_nx   = err_q;
        unique case (state)
            IDLE: begin
                stall_nx = '0;
                if (win_valid) begin
                    state_nx = LOCKED;
                    grant_nx = winner;
                end
            end
            LOCKED: begin
                if (release_c) begin
                    last_nx  = owner_idx;
                    stall_nx = '0;
                    if (win_valid) begin
                        grant_nx = winner;
                    end else begin
                        grant_nx = '0;
                        state_nx = IDLE;
                    end
                end else if (xfer) begin
                    stall_nx = '0;
                end else if (stall_cnt != '1) begin
                    stall_nx = stall_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
        if (stall_nx >= LIMIT) err_nx = 1'b1;
        if (port.clear_error) begin
            stall_nx = '0;
            err_nx   = 1'b0;
        end
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state      <= IDLE;
            grant_q    <= '0;
            last_owner <= IW'(CHANNELS - 1);
            stall_cnt  <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            grant_q    <= grant_nx;
            last_owner <= last_nx;
            stall_cnt  <= stall_nx;
            err_q      <= err_nx;
        end
    end

    assign port.grant       = grant_q;
    assign port.busy        = (state == LOCKED);
    assign port.stall_error = err_q;

endmodule

// File: tb/tb_noc_port_vc_arbiter.sv
// Directed bench for noc_port_vc_arbiter; expected grants go to
// a scoreboard queue drained by a negedge monitor.
module tb_noc_port_vc_arbiter;
    import Noc_parameters::*;

    localparam logic [3:0] F = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_port_vc_arbiter_if #(.CHANNELS(4)) bus ();

    noc_port_vc_arbiter #(
        .CHANNELS    (4),
        .STALL_LIMIT (4)
    ) dut (
        .noc_clk (clk),
        .noc_rst (rst),
        .port    (bus)
    );

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.busy === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_grant", 32'(bus.grant), 0);
            end else begin
                chk("sb_grant", 32'(bus.grant), 32'(sb.pop_front()));
            end
        end
    end

    task automatic drive(input logic [3:0] req, sop, eop, fr,
                         input logic clr);
        bus.request         = req;
        bus.start_of_packet = sop;
        bus.end_of_packet   = eop;
        bus.free            = fr;
        bus.clear_error     = clr;
    endtask

    task automatic cyc(input logic [3:0] req, sop, eop, fr,
                       input logic clr,
                       input logic [3:0] exp_g);
        drive(req, sop, eop, fr, clr);
        @(posedge clk);
        #1;
        if (exp_g != 4'h0) sb.push_back(exp_g);
    endtask

    task automatic do_reset();
        drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("reset_grant", 32'(bus.grant), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_stall_error", 32'(bus.stall_error), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        #1;

        // single header on ch0 right after reset
        do_reset();
        cyc(4'h1, 4'h1, 4'h0, F, 1'b0, 4'h1);
        chk("req031_grant", 32'(bus.grant), 32'h1);
        chk("req031_busy", 32'(bus.busy), 1);
        cyc(4'h1, 4'h1, 4'h1, F, 1'b0, 4'h0);
        chk("req031_release", 32'(bus.busy), 0);

        // ch0 and ch2 collide, zero-bubble handover
        do_reset();
        cyc(4'h5, 4'h5, 4'h0, F, 1'b0, 4'h1);
        cyc(4'h5, 4'h5, 4'h0, F, 1'b0, 4'h1);
        cyc(4'h5, 4'h4, 4'h0, F, 1'b0, 4'h1);
        cyc(4'h5, 4'h4, 4'h1, F, 1'b0, 4'h4);
        chk("req032_no_bubble", 32'(bus.grant), 32'h4);
        cyc(4'h5, 4'h5, 4'h0, F, 1'b0, 4'h4);
        cyc(4'h5, 4'h1, 4'h0, F, 1'b0, 4'h4);
        cyc(4'h5, 4'h1, 4'h4, F, 1'b0, 4'h1);
        chk("req032_ch0_waits", 32'(bus.grant), 32'h1);
        cyc(4'h1, 4'h1, 4'h1, F, 1'b0, 4'h0);
        chk("req032_idle", 32'(bus.busy), 0);

        // owner 1 holds against ch3 header and foreign eop
        do_reset();
        cyc(4'h2, 4'h2, 4'h0, F, 1'b0, 4'h2);
        cyc(4'h2, 4'h2, 4'h0, F, 1'b0, 4'h2);
        cyc(4'hA, 4'h8, 4'h0, F, 1'b0, 4'h2);
        cyc(4'hA, 4'h8, 4'h8, F, 1'b0, 4'h2);
        chk("req033_hold", 32'(bus.grant), 32'h2);
        cyc(4'hA, 4'h8, 4'h2, F, 1'b0, 4'h8);
        chk("req033_handover", 32'(bus.grant), 32'h8);
        cyc(4'h8, 4'h8, 4'h8, F, 1'b0, 4'h0);
        chk("req033_idle", 32'(bus.busy), 0);

        // stall detection, clear, clear beats limit
        do_reset();
        cyc(4'h1, 4'h1, 4'h0, F, 1'b0, 4'h1);
        for (int i = 0; i < 3; i++)
            cyc(4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1);
        chk("req034_below_limit", 32'(bus.stall_error), 0);
        cyc(4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1);
        chk("req034_set", 32'(bus.stall_error), 1);
        chk("req034_grant_held", 32'(bus.grant), 32'h1);
        cyc(4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 4'h1);
        chk("req034_cleared", 32'(bus.stall_error), 0);
        for (int i = 0; i < 3; i++)
            cyc(4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1);
        cyc(4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 4'h1);
        chk("req024_clear_wins", 32'(bus.stall_error), 0);
        cyc(4'h1, 4'h1, 4'h1, F, 1'b0, 4'h0);
        chk("req034_release", 32'(bus.busy), 0);
        chk("req034_err_after", 32'(bus.stall_error), 0);

        // async reset mid-packet on owner 2
        do_reset();
        cyc(4'h4, 4'h4, 4'h0, F, 1'b0, 4'h0);
        chk("req035_pre", 32'(bus.grant), 32'h4);
        drive(4'h4, 4'h0, 4'h0, F, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("req035_async_grant", 32'(bus.grant), 0);
        chk("req035_async_busy", 32'(bus.busy), 0);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(4'h9, 4'h9, 4'h0, F, 1'b0, 4'h1);
        chk("req035_ch0_first", 32'(bus.grant), 32'h1);
        cyc(4'h9, 4'h9, 4'h1, F, 1'b0, 4'h8);
        cyc(4'h8, 4'h8, 4'h8, F, 1'b0, 4'h0);

        // single-flit packets on every VC rotate
        do_reset();
        cyc(F, F, 4'h0, F, 1'b0, 4'h1);
        cyc(F, F, 4'h1, F, 1'b0, 4'h2);
        cyc(F, F, 4'h2, F, 1'b0, 4'h4);
        cyc(F, F, 4'h4, F, 1'b0, 4'h8);
        chk("req036_wrap_pre", 32'(bus.grant), 32'h8);
        cyc(F, F, 4'h8, F, 1'b0, 4'h1);
        chk("req036_wrap", 32'(bus.grant), 32'h1);
        cyc(F, F, 4'h1, F, 1'b0, 4'h2);
        cyc(4'h2, 4'h2, 4'h2, F, 1'b0, 4'h0);
        chk("req036_idle", 32'(bus.busy), 0);

        drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
